// File: rtl/traffic_pkg.sv
// Codes shared between the traffic-light controller and its consumers
// (light states, barrier-gate states, and the position width).
package traffic_pkg;

   localparam int POS_W = 4;

   typedef enum logic [1:0] {
      LIGHT_RED    = 2'b00,
      LIGHT_GREEN  = 2'b01,
      LIGHT_YELLOW = 2'b10
   } light_e;

   typedef enum logic [2:0] {
      G_CLOSED  = 3'd0,
      G_OPENING = 3'd1,
      G_OPEN    = 3'd2,
      G_CLOSING = 3'd3,
      G_FAULT   = 3'd4
   } gate_state_e;

endpackage

// File: rtl/gate_pos_counter.sv
// Tick-stepped barrier position: saturating up/down counter bounded to
// 0..MOVE_TICKS, holding when neither direction is requested.
module gate_pos_counter
   import traffic_pkg::*;
#(
   parameter int MOVE_TICKS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_i,
   input  logic             down_i,
   output logic [POS_W-1:0] pos_o,
   output logic             at_top_o,
   output logic             at_bottom_o
);

   localparam logic [POS_W-1:0] TOP = POS_W'(MOVE_TICKS);

   logic [POS_W-1:0] pos_q, pos_d;

   always_comb begin
      pos_d = pos_q;
      if (up_i && (pos_q < TOP)) begin
         pos_d = pos_q + 1'b1;
      end else if (down_i && (pos_q != '0)) begin
         pos_d = pos_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign pos_o       = pos_q;
   assign at_top_o    = (pos_q == TOP);
   assign at_bottom_o = (pos_q == '0);

endmodule

// File: rtl/gate_ctrl.sv
// Barrier-gate controller: keeps the gate open only while the light is
// GREEN, reverses on obstacles and latches FAULT after repeated obstruction.
module gate_ctrl
   import traffic_pkg::*;
#(
   parameter int MOVE_TICKS = 3,
   parameter int MAX_RETRY  = 2,
   parameter int WARN_LEFT  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [1:0]       light_state,
   input  logic [7:0]       time_left,
   input  logic             obstacle,
   input  logic             fault_clr,
   output logic             motor_up,
   output logic             motor_down,
   output logic             gate_open,
   output logic             gate_closed,
   output logic [POS_W-1:0] pos,
   output logic             beacon,
   output logic             fault,
   output logic [2:0]       gstate
);

   localparam logic [POS_W-1:0] TOP_M1 = POS_W'(MOVE_TICKS - 1);
   localparam logic [POS_W-1:0] ONE    = POS_W'(1);
   localparam logic [2:0]       MAX_R  = 3'(MAX_RETRY);
   localparam logic [7:0]       WARN   = 8'(WARN_LEFT);

   gate_state_e state_q, state_d;
   logic [2:0]  retry_q, retry_d;
   logic        reopen_q, reopen_d;
   logic        up_cmd, down_cmd;
   logic        at_top, at_bottom;
   logic        is_green;
   logic        beacon_d;

   logic motor_up_q, motor_down_q, gate_open_q, gate_closed_q, beacon_q, fault_q;

   assign is_green = (light_state == LIGHT_GREEN);

   gate_pos_counter #(.MOVE_TICKS(MOVE_TICKS)) u_pos (
      .clk         (clk),
      .rst         (rst),
      .up_i        (up_cmd),
      .down_i      (down_cmd),
      .pos_o       (pos),
      .at_top_o    (at_top),
      .at_bottom_o (at_bottom)
   );

   always_comb begin
      state_d  = state_q;
      retry_d  = retry_q;
      reopen_d = reopen_q;
      up_cmd   = 1'b0;
      down_cmd = 1'b0;
      unique case (state_q)
         G_CLOSED: begin
            if (is_green) begin
               state_d  = G_OPENING;
               reopen_d = 1'b0;
            end
         end
         G_OPENING: begin
            // A reopen after an obstacle must finish travel before obeying the light.
            if (!reopen_q && !is_green) begin
               state_d = G_CLOSING;
            end else if (tick) begin
               up_cmd = 1'b1;
               if (at_top || (pos == TOP_M1)) begin
                  state_d  = G_OPEN;
                  reopen_d = 1'b0;
               end
            end
         end
         G_OPEN: begin
            if (is_green) begin
               retry_d = '0;
            end else if (!obstacle) begin
               state_d = G_CLOSING;
            end
         end
         G_CLOSING: begin
            if (obstacle) begin
               if (retry_q < MAX_R) begin
                  state_d  = G_OPENING;
                  reopen_d = 1'b1;
                  retry_d  = retry_q + 3'd1;
               end else begin
                  state_d = G_FAULT;
               end
            end else if (is_green) begin
               state_d  = G_OPENING;
               reopen_d = 1'b0;
            end else if (tick) begin
               down_cmd = 1'b1;
               if (at_bottom || (pos == ONE)) begin
                  state_d = G_CLOSED;
                  retry_d = '0;
               end
            end
         end
         G_FAULT: begin
            if (fault_clr) begin
               state_d  = G_OPENING;
               reopen_d = 1'b1;
               retry_d  = '0;
            end
         end
         default: state_d = G_CLOSED;
      endcase
   end

   // Outputs are registered from next-state so they line up with pos/gstate.
   always_comb begin
      beacon_d = (state_d == G_OPENING) || (state_d == G_CLOSING) || (state_d == G_FAULT) ||
                 ((state_d == G_OPEN) && is_green && (time_left <= WARN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= G_CLOSED;
         retry_q       <= '0;
         reopen_q      <= 1'b0;
         motor_up_q    <= 1'b0;
         motor_down_q  <= 1'b0;
         gate_open_q   <= 1'b0;
         gate_closed_q <= 1'b1;
         beacon_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         retry_q       <= retry_d;
         reopen_q      <= reopen_d;
         motor_up_q    <= (state_d == G_OPENING);
         motor_down_q  <= (state_d == G_CLOSING);
         gate_open_q   <= (state_d == G_OPEN);
         gate_closed_q <= (state_d == G_CLOSED);
         beacon_q      <= beacon_d;
         fault_q       <= (state_d == G_FAULT);
      end
   end

   assign motor_up    = motor_up_q;
   assign motor_down  = motor_down_q;
   assign gate_open   = gate_open_q;
   assign gate_closed = gate_closed_q;
   assign beacon      = beacon_q;
   assign fault       = fault_q;
   assign gstate      = state_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Directed walk through the gate scenarios followed by random traffic,
// all compared against a behavioural model of the gate rules.
module tb_gate_ctrl;

   localparam int MT   = 3;
   localparam int MAXR = 2;
   localparam int WL   = 2;

   localparam logic [1:0] R = 2'b00;
   localparam logic [1:0] G = 2'b01;
   localparam logic [1:0] Y = 2'b10;

   logic       clk = 1'b0;
   logic       rst, tick, obstacle, fault_clr;
   logic [1:0] light_state;
   logic [7:0] time_left;
   logic       motor_up, motor_down, gate_open, gate_closed, beacon, fault;
   logic [3:0] pos;
   logic [2:0] gstate;

   int checks   = 0;
   int failures = 0;

   // model state: 0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING, 4 FAULT
   int ms = 0, mp = 0, mr = 0, mo = 0;
   int exp_beacon = 0;

   gate_ctrl #(.MOVE_TICKS(MT), .MAX_RETRY(MAXR), .WARN_LEFT(WL)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .light_state (light_state),
      .time_left   (time_left),
      .obstacle    (obstacle),
      .fault_clr   (fault_clr),
      .motor_up    (motor_up),
      .motor_down  (motor_down),
      .gate_open   (gate_open),
      .gate_closed (gate_closed),
      .pos         (pos),
      .beacon      (beacon),
      .fault       (fault),
      .gstate      (gstate)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic [1:0] l, input logic [7:0] tl,
                        input logic ob, input logic tk, input logic fc);
      bit green;
      green = (l == G);
      if (r) begin
         ms = 0; mp = 0; mr = 0; mo = 0;
      end else begin
         case (ms)
            0: if (green) begin ms = 1; mo = 0; end
            1: begin
               if (mo == 0 && !green) ms = 3;
               else if (tk) begin
                  mp = (mp + 1 > MT) ? MT : mp + 1;
                  if (mp == MT) begin ms = 2; mo = 0; end
               end
            end
            2: begin
               if (green) mr = 0;
               else if (!ob) ms = 3;
            end
            3: begin
               if (ob) begin
                  if (mr < MAXR) begin ms = 1; mo = 1; mr = mr + 1; end
                  else ms = 4;
               end else if (green) begin
                  ms = 1; mo = 0;
               end else if (tk) begin
                  mp = (mp > 0) ? mp - 1 : 0;
                  if (mp == 0) begin ms = 0; mr = 0; end
               end
            end
            default: if (fc) begin ms = 1; mo = 1; mr = 0; end
         endcase
      end
      exp_beacon = (ms == 1 || ms == 3 || ms == 4 ||
                    (!r && ms == 2 && green && int'(tl) <= WL)) ? 1 : 0;
   endtask

   task automatic step(input logic r, input logic [1:0] l, input logic [7:0] tl,
                       input logic ob, input logic tk, input logic fc);
      rst = r; light_state = l; time_left = tl; obstacle = ob; tick = tk; fault_clr = fc;
      @(posedge clk);
      model(r, l, tl, ob, tk, fc);
      #1;
      chk("gstate",      8'(gstate),      8'(ms));
      chk("pos",         8'(pos),         8'(mp));
      chk("motor_up",    8'(motor_up),    8'(ms == 1));
      chk("motor_down",  8'(motor_down),  8'(ms == 3));
      chk("gate_open",   8'(gate_open),   8'(ms == 2 && mp == MT));
      chk("gate_closed", 8'(gate_closed), 8'(ms == 0 && mp == 0));
      chk("fault",       8'(fault),       8'(ms == 4));
      chk("beacon",      8'(beacon),      8'(exp_beacon));
      chk("motor_excl",  8'(motor_up & motor_down), 8'd0);
      $display("step rst=%0b light=%0d tl=%0d obs=%0b tick=%0b clr=%0b -> st=%0d pos=%0d up=%0b dn=%0b bcn=%0b flt=%0b",
               r, l, tl, ob, tk, fc, gstate, pos, motor_up, motor_down, beacon, fault);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; obstacle = 1'b0; fault_clr = 1'b0;
      light_state = R; time_left = 8'd0;

      // reset and open on GREEN
      step(1, R, 0, 0, 0, 0);
      step(1, G, 0, 0, 1, 0);
      chk("reset_closed", 8'(gate_closed), 8'd1);
      step(0, G, 3, 0, 0, 0);
      for (int i = 0; i < MT; i++) step(0, G, 3, 0, 1, 0);
      chk("p1_pos", 8'(pos), 8'd3);
      chk("p1_open", 8'(gate_open), 8'd1);

      // beacon pre-warning and normal close
      step(0, G, 3, 0, 0, 0);
      chk("p2_beacon_off", 8'(beacon), 8'd0);
      step(0, G, 2, 0, 0, 0);
      chk("p2_beacon_on", 8'(beacon), 8'd1);
      step(0, Y, 0, 0, 0, 0);
      for (int i = 0; i < MT; i++) step(0, Y, 0, 0, 1, 0);
      chk("p2_closed", 8'(gate_closed), 8'd1);

      // obstacle reversal completes opening despite RED
      step(0, G, 9, 0, 0, 0);
      for (int i = 0; i < MT; i++) step(0, G, 9, 0, 1, 0);
      step(0, Y, 0, 0, 0, 0);
      step(0, Y, 0, 0, 1, 0);
      step(0, R, 0, 1, 1, 0);
      chk("p3_reopen_pos", 8'(pos), 8'd2);
      step(0, R, 0, 0, 0, 0);
      step(0, R, 0, 0, 1, 0);
      chk("p3_open", 8'(gstate), 8'd2);
      step(0, R, 0, 0, 0, 0);

      // repeated obstruction leads to FAULT, then recovery
      step(0, R, 0, 0, 1, 0);
      step(0, R, 0, 1, 0, 0);
      step(0, R, 0, 0, 1, 0);
      step(0, R, 0, 0, 0, 0);
      step(0, R, 0, 1, 0, 0);
      chk("p4_fault", 8'(fault), 8'd1);
      step(0, G, 0, 1, 1, 0);
      step(0, R, 0, 0, 1, 0);
      chk("p4_frozen", 8'(pos), 8'd3);
      step(0, R, 0, 0, 0, 1);
      step(0, R, 0, 0, 1, 0);
      step(0, R, 0, 0, 0, 0);
      for (int i = 0; i < MT; i++) step(0, R, 0, 0, 1, 0);
      chk("p4_closed", 8'(gstate), 8'd0);

      // light drops during opening
      step(0, G, 5, 0, 0, 0);
      step(0, G, 5, 0, 1, 0);
      step(0, R, 0, 0, 1, 0);
      chk("p5_pos_kept", 8'(pos), 8'd1);
      step(0, R, 0, 0, 1, 0);
      chk("p5_closed", 8'(gate_closed), 8'd1);

      // reset mid-closing
      step(0, G, 5, 0, 0, 0);
      for (int i = 0; i < MT; i++) step(0, G, 5, 0, 1, 0);
      step(0, Y, 0, 0, 0, 0);
      step(0, Y, 0, 0, 1, 0);
      step(1, Y, 0, 1, 1, 0);
      chk("p6_pos", 8'(pos), 8'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [1:0] l;
         int sel;
         sel = int'($urandom_range(0, 9));
         l = (sel < 5) ? G : (sel < 7) ? R : (sel < 9) ? Y : 2'b11;
         step(($urandom_range(0, 199) == 0), l, 8'($urandom_range(0, 5)),
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gate_ctrl.md
Name: gate_ctrl

Overview:
- Consumer end of the traffic-light interface: takes the light state code and time_left from the light controller and drives a barrier-gate motor so that the gate is open only while the light is GREEN.
- Models gate travel as a tick-counted position, reverses on obstacle and latches a fault after repeated obstructions.
- Drives a warning beacon.
- Sits beside the light controller and shares its 1 s tick.

Parameters:
- MOVE_TICKS, 3: ticks for full travel (closed to open, or open to closed); range 1..15.
- MAX_RETRY, 2: obstacle reversals allowed per close attempt before FAULT; range 1..7.
- WARN_LEFT, 2: beacon pre-warns in OPEN when time_left <= WARN_LEFT during GREEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse, 1 s time base (same as the light controller).
- light_state  in  2  00 RED, 01 GREEN, 10 YELLOW; 11 treated as not-GREEN.
- time_left  in  8  remaining ticks of the current light phase.
- obstacle  in  1  level, high = object under the barrier.
- fault_clr  in  1  one-cycle pulse, acknowledges FAULT.
- motor_up  out  1  drive gate opening.
- motor_down  out  1  drive gate closing.
- gate_open  out  1  pos == MOVE_TICKS and state OPEN.
- gate_closed  out  1  pos == 0 and state CLOSED.
- pos  out  4  current gate position, 0 = closed.
- beacon  out  1  warning lamp.
- fault  out  1  high while in FAULT.
- gstate  out  3  current state code, for debug.

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge, including mid-motion) forces state CLOSED, pos=0, retry=0 and reopen=0. All outputs are 0 except gate_closed=1.
- States: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4.
- Evaluation priority each cycle: FAULT handling > obstacle > light_state > tick.
- CLOSED:
  - light_state==GREEN -> OPENING on the next edge.
  - obstacle is ignored while in CLOSED.
- OPENING (motor_up=1):
  - On tick, pos+1.
  - The tick where pos==MOVE_TICKS-1 sets pos=MOVE_TICKS and moves to OPEN, clearing reopen.
  - If reopen==0 and light_state!=GREEN: reverse to CLOSING on the same edge. pos is kept, and no increment happens on that cycle's tick.
  - If reopen==1: light_state is ignored until fully open.
- OPEN (motors off):
  - light_state!=GREEN and obstacle==0 -> CLOSING.
  - With obstacle==1, stays OPEN regardless of light.
  - light_state==GREEN clears retry.
- CLOSING (motor_down=1):
  - On tick, pos-1. The tick where pos==1 sets pos=0 and moves to CLOSED, clearing retry.
  - obstacle==1 and retry<MAX_RETRY: -> OPENING with reopen=1 and retry+1; no decrement that cycle.
  - obstacle==1 and retry==MAX_RETRY: -> FAULT.
  - light_state==GREEN (and no obstacle): -> OPENING with reopen=0.
- FAULT:
  - Motors off, pos frozen, fault=1.
  - fault_clr -> OPENING with reopen=1 and retry=0. All other inputs are ignored.
- Boundaries:
  - pos never leaves 0..MOVE_TICKS.
  - motor_up and motor_down are never both 1.
  - A tick coinciding with a state change affects pos only as stated above.
  - MOVE_TICKS=1: a single tick completes travel.
- beacon=1 in OPENING, CLOSING and FAULT, and in OPEN when light_state==GREEN and time_left<=WARN_LEFT. Otherwise 0.
- Latency: each input change is reflected in the outputs one clk edge later.

Decomposition:
- Shared package traffic_pkg:
  - Light codes: RED, GREEN, YELLOW.
  - Gate state codes: CLOSED..FAULT.
  - Position width constant: 4.
- One natural sub-module: gate_pos_counter, a tick-driven up/down counter with hold, bounded 0..MOVE_TICKS, with at_top and at_bottom flags.
- The FSM stays in gate_ctrl.

Test Plan (MOVE_TICKS=3, MAX_RETRY=2, WARN_LEFT=2):
1. Reset, then light=GREEN and 3 ticks -> OPENING with pos 1,2,3, then OPEN, gate_open=1, motor_up=0.
2. OPEN, GREEN, time_left 3 then 2 -> beacon 0, then 1. light=YELLOW -> CLOSING; 3 ticks -> pos 2,1,0, then CLOSED, gate_closed=1.
3. CLOSING at pos=2 with obstacle pulsed -> OPENING with reopen=1; light=RED held, gate still reaches OPEN. Obstacle low -> CLOSING again.
4. Obstacle on 3 successive closings (retry 1, 2, then the third) -> FAULT, fault=1, motors 0, pos frozen. fault_clr -> OPENING, then OPEN, then CLOSING, then CLOSED.
5. OPENING at pos=1, light goes RED -> CLOSING next edge with pos=1; one tick -> CLOSED.
6. rst asserted in CLOSING at pos=2 -> next edge: CLOSED, pos=0, all outputs 0 except gate_closed=1.
